// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a controller and the PS/2 host transmitter.
// The controller drives tx_data/tx_valid; the transmitter reports ready, busy and outcome pulses.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop release and device ack, with an inter-edge watchdog. Drives open-drain pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx_bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_pull,
    output logic         ps2_data_pull
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_BITS      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [2:0]             state_reg;
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    logic [9:0]             frame_reg;
    logic [3:0]             bit_cnt_reg;
    logic [INH_W-1:0]       inh_cnt_reg;
    logic [WD_W-1:0]        wd_cnt_reg;
    logic                   clk_pull_reg;
    logic                   data_pull_reg;
    logic                   done_reg;
    logic                   error_reg;

    logic clk_s;
    logic data_s;
    logic fe;
    logic tx_ready_int;
    logic wd_expired;

    assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];
    assign fe     = clk_prev_reg & ~clk_s;

    // Ready is withheld during the done/error cycle so a held request starts on the following one.
    assign tx_ready_int = (state_reg == ST_IDLE) && !done_reg && !error_reg;
    assign wd_expired   = !fe && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    assign tx_bus.tx_ready = tx_ready_int;
    assign tx_bus.busy     = (state_reg != ST_IDLE);
    assign tx_bus.done     = done_reg;
    assign tx_bus.error    = error_reg;
    assign ps2_clk_pull    = clk_pull_reg;
    assign ps2_data_pull   = data_pull_reg;

    // Idle-high lines, so the synchronizers preset to 1 to avoid a false edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev_reg  <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            frame_reg     <= '0;
            bit_cnt_reg   <= '0;
            inh_cnt_reg   <= '0;
            wd_cnt_reg    <= '0;
            clk_pull_reg  <= 1'b0;
            data_pull_reg <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    clk_pull_reg  <= 1'b0;
                    data_pull_reg <= 1'b0;
                    if (tx_bus.tx_valid && tx_ready_int) begin
                        // Frame shifted out LSB first: d0..d7, odd parity, stop.
                        frame_reg    <= {1'b1, ~^tx_bus.tx_data, tx_bus.tx_data};
                        inh_cnt_reg  <= '0;
                        clk_pull_reg <= 1'b1;
                        state_reg    <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) begin
                        clk_pull_reg  <= 1'b0;
                        data_pull_reg <= 1'b1;
                        wd_cnt_reg    <= '0;
                        state_reg     <= ST_RELEASE;
                    end else begin
                        inh_cnt_reg <= inh_cnt_reg + 1'b1;
                    end
                end
                ST_RELEASE, ST_BITS, ST_ACK, ST_WAIT_IDLE: begin
                    if (fe) begin
                        wd_cnt_reg <= '0;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                    if (wd_expired) begin
                        error_reg     <= 1'b1;
                        clk_pull_reg  <= 1'b0;
                        data_pull_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end else begin
                        case (state_reg)
                            ST_RELEASE: begin
                                if (fe) begin
                                    bit_cnt_reg <= '0;
                                    state_reg   <= ST_BITS;
                                end
                            end
                            ST_BITS: begin
                                if (fe) begin
                                    data_pull_reg <= ~frame_reg[0];
                                    frame_reg     <= {1'b0, frame_reg[9:1]};
                                    bit_cnt_reg   <= bit_cnt_reg + 1'b1;
                                    if (bit_cnt_reg == 4'd9) begin
                                        state_reg <= ST_ACK;
                                    end
                                end
                            end
                            ST_ACK: begin
                                if (fe) begin
                                    data_pull_reg <= 1'b0;
                                    if (data_s) begin
                                        error_reg <= 1'b1;
                                        state_reg <= ST_IDLE;
                                    end else begin
                                        state_reg <= ST_WAIT_IDLE;
                                    end
                                end
                            end
                            default: begin
                                if (clk_s && data_s) begin
                                    done_reg  <= 1'b1;
                                    state_reg <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    clk_pull_reg  <= 1'b0;
                    data_pull_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
